// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and status codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] AOK  = 3'd1;
  localparam logic [2:0] HLT  = 3'd2;
  localparam logic [2:0] ADR  = 3'd3;
  localparam logic [2:0] INS  = 3'd4;

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational read ports, two write ports
// (M port wins on a shared ID), synchronous clear on reset.
module y86_regfile #(
  parameter int W    = 64,
  parameter int NREG = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   rd_a_id_i,
  input  logic [3:0]   rd_b_id_i,
  output logic [W-1:0] rd_a_o,
  output logic [W-1:0] rd_b_o,
  input  logic [3:0]   wr_e_id_i,
  input  logic [W-1:0] wr_e_val_i,
  input  logic [3:0]   wr_m_id_i,
  input  logic [W-1:0] wr_m_val_i
);

  logic [W-1:0] regs_q [NREG];

  // Unimplemented IDs (including RNONE) simply match no entry, so they read 0.
  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_a_id_i == 4'(i)) rd_a_o = regs_q[i];
      if (rd_b_id_i == 4'(i)) rd_b_o = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst)                     regs_q[i] <= '0;
      else if (wr_m_id_i == 4'(i)) regs_q[i] <= wr_m_val_i;
      else if (wr_e_id_i == 4'(i)) regs_q[i] <= wr_e_val_i;
    end
  end

endmodule

// File: rtl/y86_pipe_decode.sv
// Pipelined Y86-64 decode stage: register selection, register file, operand
// forwarding, load-use detection and the D->E pipeline register.
module y86_pipe_decode
  import y86_pkg::*;
#(
  parameter int W    = 64,
  parameter int NREG = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   D_stat,
  input  logic [3:0]   D_icode,
  input  logic [3:0]   D_ifun,
  input  logic [3:0]   D_rA,
  input  logic [3:0]   D_rB,
  input  logic [W-1:0] D_valC,
  input  logic [W-1:0] D_valP,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   M_dstE,
  input  logic [W-1:0] M_valE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   W_dstE,
  input  logic [W-1:0] W_valE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valM,
  input  logic         E_stall,
  input  logic         E_bubble,
  output logic [2:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic         load_use
);

  logic [3:0]   d_dstE, d_dstM;
  logic [W-1:0] rf_a, rf_b;
  logic [W-1:0] d_valA, d_valB;

  logic [2:0]   E_stat_q,  E_stat_d;
  logic [3:0]   E_icode_q, E_icode_d;
  logic [3:0]   E_ifun_q,  E_ifun_d;
  logic [W-1:0] E_valC_q,  E_valC_d;
  logic [W-1:0] E_valA_q,  E_valA_d;
  logic [W-1:0] E_valB_q,  E_valB_d;
  logic [3:0]   E_dstE_q,  E_dstE_d;
  logic [3:0]   E_dstM_q,  E_dstM_d;
  logic [3:0]   E_srcA_q,  E_srcA_d;
  logic [3:0]   E_srcB_q,  E_srcB_d;

  // cmov dstE passes through unconditionally; execute resolves the condition.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    if (D_icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) d_srcA = D_rA;
    else if (D_icode inside {I_RET, I_POPQ})                 d_srcA = RSP;
    if (D_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ})          d_srcB = D_rB;
    else if (D_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) d_srcB = RSP;
    if (D_icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ})          d_dstE = D_rB;
    else if (D_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) d_dstE = RSP;
    if (D_icode inside {I_MRMOVQ, I_POPQ})                   d_dstM = D_rA;
  end

  y86_regfile #(.W(W), .NREG(NREG)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rd_a_id_i  (d_srcA),
    .rd_b_id_i  (d_srcB),
    .rd_a_o     (rf_a),
    .rd_b_o     (rf_b),
    .wr_e_id_i  (W_dstE),
    .wr_e_val_i (W_valE),
    .wr_m_id_i  (W_dstM),
    .wr_m_val_i (W_valM)
  );

  // Youngest producer first; an RNONE source never forwards.
  always_comb begin
    d_valA = rf_a;
    if (D_icode inside {I_JXX, I_CALL})                d_valA = D_valP;
    else if (d_srcA != RNONE && d_srcA == e_dstE)      d_valA = e_valE;
    else if (d_srcA != RNONE && d_srcA == M_dstM)      d_valA = m_valM;
    else if (d_srcA != RNONE && d_srcA == M_dstE)      d_valA = M_valE;
    else if (d_srcA != RNONE && d_srcA == W_dstM)      d_valA = W_valM;
    else if (d_srcA != RNONE && d_srcA == W_dstE)      d_valA = W_valE;

    d_valB = rf_b;
    if (d_srcB != RNONE && d_srcB == e_dstE)           d_valB = e_valE;
    else if (d_srcB != RNONE && d_srcB == M_dstM)      d_valB = m_valM;
    else if (d_srcB != RNONE && d_srcB == M_dstE)      d_valB = M_valE;
    else if (d_srcB != RNONE && d_srcB == W_dstM)      d_valB = W_valM;
    else if (d_srcB != RNONE && d_srcB == W_dstE)      d_valB = W_valE;
  end

  assign load_use = (E_icode_q inside {I_MRMOVQ, I_POPQ}) && (E_dstM_q != RNONE) &&
                    ((E_dstM_q == d_srcA) || (E_dstM_q == d_srcB));

  always_comb begin
    E_stat_d  = E_stat_q;
    E_icode_d = E_icode_q;
    E_ifun_d  = E_ifun_q;
    E_valC_d  = E_valC_q;
    E_valA_d  = E_valA_q;
    E_valB_d  = E_valB_q;
    E_dstE_d  = E_dstE_q;
    E_dstM_d  = E_dstM_q;
    E_srcA_d  = E_srcA_q;
    E_srcB_d  = E_srcB_q;
    if (rst || E_bubble) begin
      E_stat_d  = SBUB;
      E_icode_d = I_NOP;
      E_ifun_d  = 4'h0;
      E_valC_d  = '0;
      E_valA_d  = '0;
      E_valB_d  = '0;
      E_dstE_d  = RNONE;
      E_dstM_d  = RNONE;
      E_srcA_d  = RNONE;
      E_srcB_d  = RNONE;
    end else if (!E_stall) begin
      E_stat_d  = D_stat;
      E_icode_d = D_icode;
      E_ifun_d  = D_ifun;
      E_valC_d  = D_valC;
      E_valA_d  = d_valA;
      E_valB_d  = d_valB;
      E_dstE_d  = d_dstE;
      E_dstM_d  = d_dstM;
      E_srcA_d  = d_srcA;
      E_srcB_d  = d_srcB;
    end
  end

  always_ff @(posedge clk) begin
    E_stat_q  <= E_stat_d;
    E_icode_q <= E_icode_d;
    E_ifun_q  <= E_ifun_d;
    E_valC_q  <= E_valC_d;
    E_valA_q  <= E_valA_d;
    E_valB_q  <= E_valB_d;
    E_dstE_q  <= E_dstE_d;
    E_dstM_q  <= E_dstM_d;
    E_srcA_q  <= E_srcA_d;
    E_srcB_q  <= E_srcB_d;
  end

  assign E_stat  = E_stat_q;
  assign E_icode = E_icode_q;
  assign E_ifun  = E_ifun_q;
  assign E_valC  = E_valC_q;
  assign E_valA  = E_valA_q;
  assign E_valB  = E_valB_q;
  assign E_dstE  = E_dstE_q;
  assign E_dstM  = E_dstM_q;
  assign E_srcA  = E_srcA_q;
  assign E_srcB  = E_srcB_q;

endmodule

// File: tb/tb_y86_pipe_decode.sv
// Directed bench for y86_pipe_decode with hand-computed expectations.
module tb_y86_pipe_decode;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   D_stat;
  logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic         E_stall, E_bubble;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic         load_use;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_pipe_decode #(.W(W), .NREG(15)) dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .load_use(load_use)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
    D_stat = 3'd1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
    D_icode = icode; D_rA = ra; D_rB = rb;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; W_dstE = 4'h3; W_valE = 64'h55;
    tick();
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h exp 1", E_icode); end
    checks++; if (E_stat !== 3'd0) begin errors++; $display("FAIL reset_stat got %h exp 0", E_stat); end
    checks++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'hFFFF) begin errors++;
      $display("FAIL reset_ids got %h exp ffff", {E_dstE, E_dstM, E_srcA, E_srcB}); end
    checks++; if (E_valA !== 64'h0 || E_valB !== 64'h0 || E_valC !== 64'h0) begin errors++;
      $display("FAIL reset_vals got %h/%h/%h exp 0", E_valA, E_valB, E_valC); end
    idle();
    set_d(4'h6, 4'h3, 4'h3);
    tick();
    checks++; if (E_valA !== 64'h0 || E_valB !== 64'h0) begin errors++;
      $display("FAIL reset_reg3 got %h/%h exp 0", E_valA, E_valB); end
  endtask

  task automatic test_writeback_use();
    idle();
    W_dstE = 4'h3; W_valE = 64'h1234;
    tick();
    idle();
    set_d(4'h6, 4'h3, 4'h3);
    tick();
    checks++; if (E_valA !== 64'h1234 || E_valB !== 64'h1234) begin errors++;
      $display("FAIL wb_use vals got %h/%h exp 1234", E_valA, E_valB); end
    checks++; if (E_dstE !== 4'h3 || E_dstM !== 4'hF || E_icode !== 4'h6) begin errors++;
      $display("FAIL wb_use ids got dstE %h dstM %h icode %h exp 3 f 6", E_dstE, E_dstM, E_icode); end
    // same-cycle write and read: W forwarding supplies the new value
    W_dstE = 4'h3; W_valE = 64'h99;
    tick();
    checks++; if (E_valA !== 64'h99) begin errors++; $display("FAIL same_cycle_fwd got %h exp 99", E_valA); end
    idle();
    set_d(4'h6, 4'h3, 4'h3);
    tick();
    checks++; if (E_valB !== 64'h99) begin errors++; $display("FAIL rf_after_write got %h exp 99", E_valB); end
  endtask

  task automatic test_forward_priority();
    idle();
    set_d(4'h2, 4'h2, 4'h7);
    e_dstE = 4'h2; e_valE = 64'hA; W_dstE = 4'h2; W_valE = 64'hB;
    tick();
    checks++; if (E_valA !== 64'hA) begin errors++; $display("FAIL fwd_e got %h exp a", E_valA); end
    e_dstE = 4'hF;
    tick();
    checks++; if (E_valA !== 64'hB) begin errors++; $display("FAIL fwd_w_e got %h exp b", E_valA); end
    M_dstM = 4'h2; m_valM = 64'hC; M_dstE = 4'h2; M_valE = 64'hD;
    tick();
    checks++; if (E_valA !== 64'hC) begin errors++; $display("FAIL fwd_m_m got %h exp c", E_valA); end
    M_dstM = 4'hF;
    tick();
    checks++; if (E_valA !== 64'hD) begin errors++; $display("FAIL fwd_m_e got %h exp d", E_valA); end
    M_dstE = 4'hF; W_dstM = 4'h2; W_valM = 64'hE;
    tick();
    checks++; if (E_valA !== 64'hE) begin errors++; $display("FAIL fwd_w_m got %h exp e", E_valA); end
    idle();
    set_d(4'h2, 4'h2, 4'h7);
    tick();
    checks++; if (E_valA !== 64'hE) begin errors++; $display("FAIL rf_m_port_wins got %h exp e", E_valA); end
    idle();
    set_d(4'h3, 4'hF, 4'h7);
    e_valE = 64'h77; m_valM = 64'h88;
    tick();
    checks++; if (E_valA !== 64'h0 || E_valB !== 64'h0 || E_dstE !== 4'h7) begin errors++;
      $display("FAIL rnone_src got %h/%h dstE %h exp 0/0 7", E_valA, E_valB, E_dstE); end
    idle();
    set_d(4'h4, 4'h1, 4'h2);
    M_dstE = 4'h2; M_valE = 64'h5A;
    tick();
    checks++; if (E_valB !== 64'h5A || E_valA !== 64'h0) begin errors++;
      $display("FAIL fwd_valb got %h/%h exp 0/5a", E_valA, E_valB); end
  endtask

  task automatic test_dual_write();
    idle();
    W_dstE = 4'h4; W_valE = 64'h1; W_dstM = 4'h4; W_valM = 64'h2;
    tick();
    idle();
    set_d(4'h6, 4'h4, 4'hF);
    tick();
    checks++; if (E_valA !== 64'h2) begin errors++; $display("FAIL dual_write got %h exp 2", E_valA); end
  endtask

  task automatic test_call();
    idle();
    set_d(4'h8, 4'hF, 4'hF);
    D_valP = 64'h40; e_dstE = 4'h4; e_valE = 64'h999;
    tick();
    checks++; if (E_valA !== 64'h40) begin errors++; $display("FAIL call_valA got %h exp 40", E_valA); end
    checks++; if (E_srcB !== 4'h4 || E_dstE !== 4'h4 || E_dstM !== 4'hF || E_srcA !== 4'hF) begin errors++;
      $display("FAIL call_ids got srcB %h dstE %h dstM %h srcA %h exp 4 4 f f", E_srcB, E_dstE, E_dstM, E_srcA); end
    checks++; if (E_valB !== 64'h999) begin errors++; $display("FAIL call_valB got %h exp 999", E_valB); end
  endtask

  task automatic test_load_use();
    idle();
    set_d(4'h5, 4'h5, 4'h6);
    tick();
    checks++; if (E_icode !== 4'h5 || E_dstM !== 4'h5 || E_dstE !== 4'hF) begin errors++;
      $display("FAIL mrmov_load got icode %h dstM %h dstE %h exp 5 5 f", E_icode, E_dstM, E_dstE); end
    set_d(4'h2, 4'h5, 4'h0);
    #1;
    checks++; if (load_use !== 1'b1 || d_srcA !== 4'h5 || d_srcB !== 4'hF) begin errors++;
      $display("FAIL lu_srcA got lu %b srcA %h srcB %h exp 1 5 f", load_use, d_srcA, d_srcB); end
    set_d(4'h3, 4'hF, 4'h5);
    #1;
    checks++; if (load_use !== 1'b0) begin errors++; $display("FAIL lu_none got %b exp 0", load_use); end
    set_d(4'h5, 4'h0, 4'h5);
    #1;
    checks++; if (load_use !== 1'b1) begin errors++; $display("FAIL lu_srcB got %b exp 1", load_use); end
    set_d(4'h2, 4'h5, 4'h0);
    E_bubble = 1'b1;
    tick();
    checks++; if (E_icode !== 4'h1 || E_stat !== 3'd0 || E_dstM !== 4'hF || load_use !== 1'b0) begin errors++;
      $display("FAIL bubble got icode %h stat %h dstM %h lu %b exp 1 0 f 0", E_icode, E_stat, E_dstM, load_use); end
    E_bubble = 1'b0;
    set_d(4'h5, 4'h5, 4'h6); D_valC = 64'h30;
    tick();
    E_stall = 1'b1;
    set_d(4'h6, 4'h1, 4'h2); D_valC = 64'h77;
    tick();
    checks++; if (E_icode !== 4'h5 || E_valC !== 64'h30 || E_dstM !== 4'h5 || E_srcB !== 4'h6) begin errors++;
      $display("FAIL stall got icode %h valC %h dstM %h srcB %h exp 5 30 5 6", E_icode, E_valC, E_dstM, E_srcB); end
    E_bubble = 1'b1;
    tick();
    checks++; if (E_icode !== 4'h1 || E_srcB !== 4'hF || E_valC !== 64'h0) begin errors++;
      $display("FAIL stall_bubble got icode %h srcB %h valC %h exp 1 f 0", E_icode, E_srcB, E_valC); end
  endtask

  task automatic test_back_to_back();
    idle();
    D_stat = 3'd4; D_icode = 4'h0; D_ifun = 4'h3;
    tick();
    checks++; if (E_stat !== 3'd4 || E_icode !== 4'h0 || E_ifun !== 4'h3) begin errors++;
      $display("FAIL stat_pass got stat %h icode %h ifun %h exp 4 0 3", E_stat, E_icode, E_ifun); end
    D_stat = 3'd1; D_ifun = 4'h0;
    set_d(4'hA, 4'h3, 4'hF);
    tick();
    checks++; if (E_srcA !== 4'h3 || E_srcB !== 4'h4 || E_dstE !== 4'h4 || E_valA !== 64'h99) begin errors++;
      $display("FAIL push got srcA %h srcB %h dstE %h valA %h exp 3 4 4 99", E_srcA, E_srcB, E_dstE, E_valA); end
    set_d(4'h6, 4'h3, 4'h3);
    rst = 1'b1;
    tick();
    checks++; if (E_icode !== 4'h1 || E_valA !== 64'h0 || E_dstE !== 4'hF) begin errors++;
      $display("FAIL reset_midop got icode %h valA %h dstE %h exp 1 0 f", E_icode, E_valA, E_dstE); end
    rst = 1'b0;
    tick();
    checks++; if (E_valA !== 64'h0) begin errors++; $display("FAIL rf_cleared got %h exp 0", E_valA); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_writeback_use();
    test_forward_priority();
    test_dual_write();
    test_call();
    test_load_use();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
